button_pulse_gen: RTL and testbench

- Producer side of the single-cycle `signal` strobe consumed by the RGB colour-state LED driver.
- Synchronises and debounces a raw active-low push button, then emits exactly one `pulse` per clean press.
- Optionally emits auto-repeat pulses while the button is held, so holding the button steps through colours.
- Sits between the board button pin and the LED driver's `signal` input, in the same clock domain.

---
 rtl/button_pulse_gen_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 76 +++++++
 rtl/button_pulse_gen.sv | 107 ++++++++++
 tb/tb_button_pulse_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// button_pulse_gen_pkg
//
// Shared definitions for the push-button pulse generator:
//   - repeat FSM state encoding (plain 2-bit constants so the encoding is
//     visible and stable for anything that probes the state register)
//   - default timing constants for the 27 MHz board clock
// -----------------------------------------------------------------------------
package button_pulse_gen_pkg;

  // Repeat FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;  // released, waiting for a press
  localparam logic [1:0] HOLD   = 2'd1;  // pressed, waiting for first repeat
  localparam logic [1:0] REPEAT = 2'd2;  // pressed, emitting periodic repeats

  // Default timing for the 27 MHz board clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES      = 270_000;     // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 13_500_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 6_750_000;   // 250 ms
  localparam int unsigned DEF_CNT_WIDTH            = 24;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Two-flop synchroniser for the raw active-low button followed by a
// debounce counter. A new synchronised level is accepted only after it has
// differed from the current stable level for DEBOUNCE_CYCLES consecutive
// edges; any edge where they agree restarts the count.
//
// press_now / release_now are one-cycle flags that are high in the cycle
// *before* the edge on which stable flips. Registering them downstream
// therefore lands the downstream reaction on the same edge as the stable
// change, so stable, pressed and pulse all move together.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   btn_n        in   raw button pin, asynchronous, 0 = pressed
//   stable       out  debounced level, 1 = released
//   press_now    out  stable goes pressed on the next edge
//   release_now  out  stable goes released on the next edge
// -----------------------------------------------------------------------------
module btn_debounce
  import button_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic stable,
  output logic press_now,
  output logic release_now
);

  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic [CNT_WIDTH-1:0] db_cnt;
  logic                 differ;
  logic                 accept;

  // Synchroniser: both flops reset to the released level so that a button
  // held through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign differ      = (sync2 != stable);
  assign accept      = differ && (db_cnt == DB_LAST);
  assign press_now   = accept && !sync2;
  assign release_now = accept &&  sync2;

  // Debounce counter: cleared at terminal count, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b1;
      db_cnt <= '0;
    end else if (!differ) begin
      db_cnt <= '0;
    end else if (accept) begin
      stable <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// -----------------------------------------------------------------------------
// button_pulse_gen
//
// Turns a raw active-low push button into single-cycle `pulse` strobes for
// the RGB colour-state LED driver: one pulse per clean press and, when
// REPEAT_EN = 1, auto-repeat pulses while the button stays held (first after
// REPEAT_DELAY_CYCLES, then every REPEAT_PERIOD_CYCLES). Release never
// pulses, and a release landing on a repeat deadline suppresses that repeat.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high
//   btn_n      in   raw button pin, asynchronous, 0 = pressed
//   pulse      out  one-cycle strobe per accepted press or repeat
//   pressed    out  debounced level, 1 = held
//   repeating  out  1 while the FSM is in REPEAT
// -----------------------------------------------------------------------------
module button_pulse_gen
  import button_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter bit          REPEAT_EN            = 1'b1,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter int unsigned CNT_WIDTH            = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pulse,
  output logic pressed,
  output logic repeating
);

  localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD_CYCLES - 1);

  logic                 stable;
  logic                 press_now;
  logic                 release_now;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] hold_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .btn_n       (btn_n),
    .stable      (stable),
    .press_now   (press_now),
    .release_now (release_now)
  );

  assign pressed   = ~stable;
  assign repeating = (state == REPEAT);

  // Repeat FSM and pulse register. Release is checked first so it takes
  // priority over a repeat deadline falling on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pulse    <= 1'b0;
    end else if (release_now) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pulse    <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (press_now) begin
            pulse <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!REPEAT_EN) begin
            hold_cnt <= '0;
          end else if (hold_cnt == DELAY_LAST) begin
            pulse    <= 1'b1;
            hold_cnt <= '0;
            state    <= REPEAT;
          end else begin
            hold_cnt <= hold_cnt + CNT_WIDTH'(1);
          end
        end
        REPEAT: begin
          if (hold_cnt == PERIOD_LAST) begin
            pulse    <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_button_pulse_gen
//
// Two instances with DEBOUNCE_CYCLES = 4, REPEAT_DELAY_CYCLES = 10,
// REPEAT_PERIOD_CYCLES = 5: dut0 with REPEAT_EN = 0, dut1 with REPEAT_EN = 1.
// Stimulus pushes the expected pulse (cycle stamp, pressed, repeating, and the
// colour index a 3-bit LED-driver model should show after it) into a queue
// per instance; a monitor pops and compares whenever a pulse appears.
// -----------------------------------------------------------------------------
module tb_button_pulse_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0, reset1, btn0, btn1;
  logic pulse0, pressed0, rep0;
  logic pulse1, pressed1, rep1;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY_CYCLES(10),
    .REPEAT_PERIOD_CYCLES(5), .CNT_WIDTH(8)
  ) dut0 (
    .clk(clk), .reset(reset0), .btn_n(btn0),
    .pulse(pulse0), .pressed(pressed0), .repeating(rep0)
  );

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY_CYCLES(10),
    .REPEAT_PERIOD_CYCLES(5), .CNT_WIDTH(8)
  ) dut1 (
    .clk(clk), .reset(reset1), .btn_n(btn1),
    .pulse(pulse1), .pressed(pressed1), .repeating(rep1)
  );

  // Posedge count; read at a negedge it equals the number of edges so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic        pr;
    logic        rp;
    logic [2:0]  col;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] col0 = 3'd0, col1 = 3'd0;    // LED-driver colour models
  logic [2:0] ecol0 = 3'd0, ecol1 = 3'd0;  // expected colour after each push

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push0(input int unsigned at, input logic pr, input logic rp);
    exp_t e;
    ecol0 = ecol0 + 3'd1;
    e.at = at; e.pr = pr; e.rp = rp; e.col = ecol0;
    q0.push_back(e);
  endtask

  task automatic push1(input int unsigned at, input logic pr, input logic rp);
    exp_t e;
    ecol1 = ecol1 + 3'd1;
    e.at = at; e.pr = pr; e.rp = rp; e.col = ecol1;
    q1.push_back(e);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (pulse0 === 1'b1) begin
      col0 = col0 + 3'd1;
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL dut0_pulse: unexpected pulse at cycle %0d, none expected", cyc);
      end else begin
        e0 = q0.pop_front();
        if (cyc !== e0.at || pressed0 !== e0.pr || rep0 !== e0.rp || col0 !== e0.col) begin
          n_err++;
          $display("FAIL dut0_pulse: got cyc=%0d pressed=%b rep=%b col=%0d, expected cyc=%0d pressed=%b rep=%b col=%0d",
                   cyc, pressed0, rep0, col0, e0.at, e0.pr, e0.rp, e0.col);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (pulse1 === 1'b1) begin
      col1 = col1 + 3'd1;
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL dut1_pulse: unexpected pulse at cycle %0d, none expected", cyc);
      end else begin
        e1 = q1.pop_front();
        if (cyc !== e1.at || pressed1 !== e1.pr || rep1 !== e1.rp || col1 !== e1.col) begin
          n_err++;
          $display("FAIL dut1_pulse: got cyc=%0d pressed=%b rep=%b col=%0d, expected cyc=%0d pressed=%b rep=%b col=%0d",
                   cyc, pressed1, rep1, col1, e1.at, e1.pr, e1.rp, e1.col);
        end
      end
    end
  end

  // Press dut1 for `hold` cycles; pushes the press pulse and every repeat
  // that falls strictly before the debounced release edge.
  task automatic press1(input int unsigned hold);
    int unsigned n, rel;
    n   = cyc;
    rel = n + hold + 6;
    btn1 = 1'b0;
    push1(n + 6, 1'b1, 1'b0);
    for (int unsigned t = n + 16; t < rel; t += 5) push1(t, 1'b1, 1'b1);
    repeat (hold) @(negedge clk);
    btn1 = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  logic bpat [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int unsigned n, m;
    reset0 = 1'b1; reset1 = 1'b1; btn0 = 1'b1; btn1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pulse0", pulse0, 1'b0);
    chk("rst_pressed0", pressed0, 1'b0);
    chk("rst_rep0", rep0, 1'b0);
    chk("rst_pulse1", pulse1, 1'b0);
    chk("rst_pressed1", pressed1, 1'b0);
    chk("rst_rep1", rep1, 1'b0);
    reset0 = 1'b0; reset1 = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press, no repeat: single pulse on edge 6
    n = cyc;
    btn0 = 1'b0;
    push0(n + 6, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("clean_pressed_edge5", pressed0, 1'b0);
    @(negedge clk);
    chk("clean_pressed_edge6", pressed0, 1'b1);
    repeat (34) @(negedge clk);
    chk("clean_held_pressed", pressed0, 1'b1);
    chk("clean_held_norepeat", rep0, 1'b0);
    btn0 = 1'b1;
    repeat (5) @(negedge clk);
    chk("clean_release_edge5", pressed0, 1'b1);
    @(negedge clk);
    chk("clean_release_edge6", pressed0, 1'b0);
    repeat (5) @(negedge clk);

    // Bounce: 3 low, 1 high, 3 low, then high -- never accepted
    for (int i = 0; i < 8; i++) begin
      btn0 = bpat[i];
      @(negedge clk);
      chk("bounce_pressed", pressed0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bounce_pressed_after", pressed0, 1'b0);
    end

    // Eight press/release cycles: colour model steps once per press
    for (int k = 0; k < 8; k++) begin
      n = cyc;
      btn0 = 1'b0;
      push0(n + 6, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      btn0 = 1'b1;
      repeat (10) @(negedge clk);
    end
    chk("colour_wrap_b0", col0[0], 1'b1);
    chk("colour_wrap_b1", col0[1], 1'b0);
    chk("colour_wrap_b2", col0[2], 1'b0);

    // Auto-repeat: pulses at P, P+10, P+15, ..., release clear of deadlines
    press1(38);
    chk("repeat_after_release_rep", rep1, 1'b0);
    chk("repeat_after_release_pr", pressed1, 1'b0);

    // Release lands on the P+10 edge: no repeat pulse
    press1(10);
    chk("collide_rep", rep1, 1'b0);
    repeat (20) @(negedge clk);
    chk("collide_pressed", pressed1, 1'b0);

    // Reset mid-REPEAT with the button still held
    n = cyc;
    btn1 = 1'b0;
    push1(n + 6, 1'b1, 1'b0);
    push1(n + 16, 1'b1, 1'b1);
    push1(n + 21, 1'b1, 1'b1);
    repeat (21) @(negedge clk);
    #2 reset1 = 1'b1;
    #1;
    chk("midrst_pulse", pulse1, 1'b0);
    chk("midrst_pressed", pressed1, 1'b0);
    chk("midrst_rep", rep1, 1'b0);
    repeat (3) @(negedge clk);
    reset1 = 1'b0;
    m = cyc;
    push1(m + 6, 1'b1, 1'b0);
    push1(m + 16, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("postrst_pressed_edge5", pressed1, 1'b0);
    @(negedge clk);
    chk("postrst_pressed_edge6", pressed1, 1'b1);
    repeat (6) @(negedge clk);
    btn1 = 1'b1;
    repeat (20) @(negedge clk);
    chk("postrst_final_rep", rep1, 1'b0);

    n_vec++;
    if (q0.size() != 0) begin
      n_err++;
      $display("FAIL dut0_drain: %0d expected pulses never seen, required 0", q0.size());
    end
    n_vec++;
    if (q1.size() != 0) begin
      n_err++;
      $display("FAIL dut1_drain: %0d expected pulses never seen, required 0", q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
